// File: rtl/hilo_muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide producer.
// Holds the HI/LO register width, reset/write polarities, the op encodings
// seen on the EX interface and the controller state encodings.
package hilo_muldiv_pkg;

  localparam int                    REG_DATA_W   = 32;
  localparam logic [REG_DATA_W-1:0] ZERO_WORD    = '0;
  localparam logic                  RST_ENABLE   = 1'b1;
  localparam logic                  WRITE_ENABLE = 1'b1;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MADD  = 3'b100,
    OP_MADDU = 3'b101,
    OP_MSUB  = 3'b110,
    OP_MSUBU = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  // Even encodings are the signed flavours of each op pair.
  function automatic logic op_is_signed(md_op_e o);
    return !o[0];
  endfunction

endpackage

// File: rtl/hilo_muldiv_div_core.sv
// div_core: unsigned radix-2 restoring divider, one quotient bit per step.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   clear               load dividend/divisor, zero the partial remainder
//   step                perform one iteration (W steps give the result)
//   dividend, divisor   unsigned operands, sampled on clear
//   quotient, remainder results, valid after W steps
module div_core
  import hilo_muldiv_pkg::*;
#(
  parameter int W = REG_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  logic [W-1:0] dvs_q, quo_q, rem_q;
  logic [W:0]   trial, diff;

  // Shift the next dividend bit into the partial remainder; a clear top bit
  // of the difference means trial >= divisor.
  assign trial = {rem_q, quo_q[W-1]};
  assign diff  = trial - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      dvs_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
    end else if (clear) begin
      dvs_q <= divisor;
      quo_q <= dividend;
      rem_q <= '0;
    end else if (step) begin
      if (!diff[W]) begin
        rem_q <= diff[W-1:0];
        quo_q <= {quo_q[W-2:0], 1'b1};
      end else begin
        rem_q <= trial[W-1:0];
        quo_q <= {quo_q[W-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: producer side of the HI/LO register interface.
// Takes MULT/MULTU (2-cycle write) and DIV/DIVU (32 iterations, write 34
// cycles after accept) from EX, stalls the pipe while busy and emits one
// cycle HI/LO write strobes. Divide by zero writes LO=all ones, HI=opa.
// Optional: HILO_MADD_EN enables MADD/MADDU/MSUB/MSUBU accumulate into
// {hi_in,lo_in}; without it those ops are accepted and dropped.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   start, op, opa, opb          op request from EX
//   cancel                       flush; aborts the op in flight
//   hi_in, lo_in                 current HI/LO (accumulate ops only)
//   stall                        hold the pipeline
//   we_hi/hi_data_out, we_lo/lo_data_out, div_zero   write port
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int DATA_W    = REG_DATA_W,
  parameter int DIV_CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  input  logic              cancel,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  output logic              stall,
  output logic              we_hi,
  output logic [DATA_W-1:0] hi_data_out,
  output logic              we_lo,
  output logic [DATA_W-1:0] lo_data_out,
  output logic              div_zero
);

  // 32 iterations at counts 0..31; count 32 is the sign-fixup/latch cycle.
  localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(DATA_W);

  typedef struct packed {
    md_op_e            op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } req_t;

  md_state_e state_q, state_d, dest;
  req_t      req_q;
  logic      dz_q, accept, load, in_div, in_signed, sgn_q;
  logic      we_q, dz_out_q;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic [DATA_W-1:0]    mag_a, mag_b, quo, rem, quo_fix, rem_fix, hi_q, lo_q;
  logic [2*DATA_W-1:0]  ext_a, ext_b, prod, res;
  md_op_e               op_in;

  assign op_in     = md_op_e'(op);
  assign in_div    = (op_in == OP_DIV) || (op_in == OP_DIVU);
  assign in_signed = op_is_signed(op_in);
  assign mag_a     = (in_signed && opa[DATA_W-1]) ? -opa : opa;
  assign mag_b     = (in_signed && opb[DATA_W-1]) ? -opb : opb;

  div_core #(.W(DATA_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .step      ((state_q == MD_DIV) && (cnt_q != CNT_LAST)),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (quo),
    .remainder (rem)
  );

`ifdef HILO_MADD_EN
  logic [2*DATA_W-1:0] acc_q;
`else
  logic unused_madd;
  assign unused_madd = ^{hi_in, lo_in};
`endif

  // Result datapath, evaluated from the captured request.
  assign sgn_q   = op_is_signed(req_q.op);
  assign quo_fix = (sgn_q && (req_q.a[DATA_W-1] ^ req_q.b[DATA_W-1])) ? -quo : quo;
  assign rem_fix = (sgn_q && req_q.a[DATA_W-1]) ? -rem : rem;
  assign ext_a   = sgn_q ? {{DATA_W{req_q.a[DATA_W-1]}}, req_q.a} : {{DATA_W{1'b0}}, req_q.a};
  assign ext_b   = sgn_q ? {{DATA_W{req_q.b[DATA_W-1]}}, req_q.b} : {{DATA_W{1'b0}}, req_q.b};
  assign prod    = ext_a * ext_b;

  always_comb begin
    res = prod;
    case (req_q.op)
      OP_DIV, OP_DIVU: res = dz_q ? {req_q.a, {DATA_W{1'b1}}} : {rem_fix, quo_fix};
`ifdef HILO_MADD_EN
      OP_MADD, OP_MADDU: res = acc_q + prod;
      OP_MSUB, OP_MSUBU: res = acc_q - prod;
`endif
      default: res = prod;
    endcase
  end

  // Next state / control.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    load    = 1'b0;
    case (op_in)
      OP_MULT, OP_MULTU: dest = MD_MUL;
      OP_DIV, OP_DIVU:   dest = (opb == '0) ? MD_MUL : MD_DIV;
`ifdef HILO_MADD_EN
      default:           dest = MD_MUL;
`else
      default:           dest = MD_IDLE;
`endif
    endcase
    case (state_q)
      MD_IDLE, MD_DONE: begin
        state_d = MD_IDLE;
        if (start && !cancel) begin
          accept  = 1'b1;
          state_d = dest;
        end
      end
      MD_MUL: begin
        state_d = cancel ? MD_IDLE : MD_DONE;
        load    = !cancel;
      end
      MD_DIV: begin
        if (cancel) state_d = MD_IDLE;
        else if (cnt_q == CNT_LAST) begin
          state_d = MD_DONE;
          load    = 1'b1;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign stall = (start && ((state_q == MD_IDLE) || (state_q == MD_DONE))) ||
                 (state_q == MD_MUL) || (state_q == MD_DIV);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) state_q <= MD_IDLE;
    else                   state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      req_q    <= '0;
      dz_q     <= 1'b0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      dz_out_q <= 1'b0;
      hi_q     <= ZERO_WORD;
      lo_q     <= ZERO_WORD;
`ifdef HILO_MADD_EN
      acc_q    <= '0;
`endif
    end else begin
      if (accept) begin
        req_q <= '{op: op_in, a: opa, b: opb};
        dz_q  <= in_div && (opb == '0);
        cnt_q <= '0;
`ifdef HILO_MADD_EN
        acc_q <= {hi_in, lo_in};
`endif
      end else if (state_q == MD_DIV) begin
        cnt_q <= cnt_q + 1'b1;
      end
      we_q     <= load ? WRITE_ENABLE : ~WRITE_ENABLE;
      dz_out_q <= load && dz_q;
      if (load) {hi_q, lo_q} <= res;
    end
  end

  // A flush in the write cycle suppresses the strobes but not the data.
  assign we_hi       = we_q && !cancel;
  assign we_lo       = we_q && !cancel;
  assign hi_data_out = hi_q;
  assign lo_data_out = lo_q;
  assign div_zero    = dz_out_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        rst, start, cancel;
  logic [2:0]  op;
  logic [31:0] opa, opb, hi_in, lo_in;
  logic        stall, we_hi, we_lo, div_zero;
  logic [31:0] hi_data_out, lo_data_out;

  hilo_muldiv dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .cancel(cancel), .hi_in(hi_in), .lo_in(lo_in), .stall(stall),
    .we_hi(we_hi), .hi_data_out(hi_data_out), .we_lo(we_lo),
    .lo_data_out(lo_data_out), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  localparam int N = 4096;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected behaviour, indexed by cycle number.
  bit        exp_we [N];
  bit        exp_dz [N];
  bit        busy   [N];
  bit [31:0] exp_hi [N];
  bit [31:0] exp_lo [N];

  int        n_chk = 0, n_fail = 0, n_writes = 0;
  bit        chk_en = 1'b0;
  logic [31:0] last_hi = '0, last_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural rules.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, b, h, l,
                                output bit wr, output int lat,
                                output logic [31:0] rh, rl, output bit dz);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p, q, r, pr;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'b0, a};           ub = {32'b0, b};
    wr = 1'b1; dz = 1'b0; lat = 2; p = '0;
    case (o)
      3'd0: p = sa * sb;
      3'd1: p = ua * ub;
      3'd2, 3'd3: begin
        if (b == 0) begin
          dz = 1'b1; p = {a, 32'hFFFFFFFF};
        end else begin
          lat = 34;
          if (o == 3'd2) begin q = sa / sb; r = sa % sb; end
          else           begin q = ua / ub; r = ua % ub; end
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
`ifdef HILO_MADD_EN
        pr = (o[0] == 1'b0) ? 64'(sa * sb) : 64'(ua * ub);
        p  = o[1] ? ({h, l} - pr) : ({h, l} + pr);
`else
        wr = 1'b0; pr = {h, l}; p = pr;
`endif
      end
    endcase
    rh = p[63:32]; rl = p[31:0];
  endfunction

  // Compare process: every cycle after the first reset edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", stall, start | busy[cyc]);
      check("we_hi", we_hi, exp_we[cyc] & ~cancel);
      check("we_lo", we_lo, exp_we[cyc] & ~cancel);
      check("div_zero", div_zero, exp_dz[cyc]);
      if (exp_we[cyc]) begin
        check("hi_data", hi_data_out, exp_hi[cyc]);
        check("lo_data", lo_data_out, exp_lo[cyc]);
      end
      if (we_hi) begin
        last_hi = hi_data_out; last_lo = lo_data_out; n_writes++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, b,
                       input logic [31:0] h = 32'h0, input logic [31:0] l = 32'h0);
    bit wr, dz; int lat; logic [31:0] rh, rl;
    model(o, a, b, h, l, wr, lat, rh, rl, dz);
    start = 1'b1; op = o; opa = a; opb = b; hi_in = h; lo_in = l;
    if (wr) begin
      exp_we[cyc+lat] = 1'b1; exp_hi[cyc+lat] = rh;
      exp_lo[cyc+lat] = rl;   exp_dz[cyc+lat] = dz;
      for (int i = 1; i < lat; i++) busy[cyc+i] = 1'b1;
    end
    tick();
    start = 1'b0;
  endtask

  // Drop everything the model expected after cycle c.
  task automatic abort(input int c);
    for (int i = c + 1; i < c + 40; i++) begin
      exp_we[i] = 1'b0; exp_dz[i] = 1'b0; busy[i] = 1'b0;
    end
  endtask

  task automatic pin_model(input string name, input logic [2:0] o, input logic [31:0] a, b, h, l,
                           input logic [31:0] eh, el, input bit edz);
    bit wr, dz; int lat; logic [31:0] rh, rl;
    model(o, a, b, h, l, wr, lat, rh, rl, dz);
    check({name, "_model"}, {rh, rl}, {eh, el});
    check({name, "_model_dz"}, dz, edz);
  endtask

  task automatic last_is(input string name, input logic [31:0] eh, el, input int w_exp);
    check({name, "_hi"}, last_hi, eh);
    check({name, "_lo"}, last_lo, el);
    check({name, "_nwr"}, n_writes, w_exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0;
    opa = '0; opb = '0; hi_in = '0; lo_in = '0;
    tick();
    chk_en = 1'b1;
    check("rst_stall", stall, 0);
    check("rst_data", {hi_data_out, lo_data_out}, 64'h0);
    start = 1'b1; op = 3'd0; opa = 32'd2; opb = 32'd2;  // reset beats start
    tick();
    check("rst_we", we_hi, 0);
    start = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("rst_idle_data", {hi_data_out, lo_data_out, 6'b0, we_lo, div_zero}, 72'h0);

    pin_model("mult",  3'd0, 32'hFFFFFFFE, 32'd3, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFA, 0);
    pin_model("multu", 3'd1, 32'hFFFFFFFE, 32'd3, 0, 0, 32'h00000002, 32'hFFFFFFFA, 0);
    pin_model("div",   3'd2, 32'hFFFFFFF9, 32'd2, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    pin_model("divu",  3'd3, 32'd100, 32'd7, 0, 0, 32'd2, 32'd14, 0);
    pin_model("divz",  3'd3, 32'h1234, 32'd0, 0, 0, 32'h1234, 32'hFFFFFFFF, 1);
    pin_model("ovf",   3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, 32'h0, 32'h80000000, 0);

    w = n_writes;
    issue(3'd0, 32'hFFFFFFFE, 32'd3); run(3);
    last_is("mult", 32'hFFFFFFFF, 32'hFFFFFFFA, w + 1);
    issue(3'd1, 32'hFFFFFFFE, 32'd3); run(3);
    last_is("multu", 32'h2, 32'hFFFFFFFA, w + 2);
    issue(3'd2, 32'hFFFFFFF9, 32'd2); run(36);
    last_is("div", 32'hFFFFFFFF, 32'hFFFFFFFD, w + 3);
    issue(3'd3, 32'd100, 32'd7); run(36);
    last_is("divu", 32'd2, 32'd14, w + 4);
    issue(3'd3, 32'h1234, 32'd0); run(3);
    last_is("divz", 32'h1234, 32'hFFFFFFFF, w + 5);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF); run(36);
    last_is("ovf", 32'h0, 32'h80000000, w + 6);

    // Flush in the middle of a divide, then a normal multiply.
    w = n_writes;
    issue(3'd2, 32'd1000, 32'd3); run(9);
    cancel = 1'b1; abort(cyc); tick(); cancel = 1'b0;
    run(40);
    check("cancel_div_nwr", n_writes, w);
    issue(3'd0, 32'd5, 32'd6); run(3);
    last_is("mult_after_cancel", 32'd0, 32'd30, w + 1);

    // Back-to-back: new divide accepted in the multiply's write cycle.
    w = n_writes;
    issue(3'd0, 32'd2, 32'd3); tick();
    issue(3'd3, 32'd9, 32'd4);
    last_is("b2b_first", 32'd0, 32'd6, w + 1);
    run(35);
    last_is("b2b_second", 32'd1, 32'd2, w + 2);

    // Flush in the write cycle gates the strobes.
    w = n_writes;
    issue(3'd0, 32'd7, 32'd7); tick();
    cancel = 1'b1; abort(cyc); tick(); cancel = 1'b0;
    run(2);
    check("cancel_done_nwr", n_writes, w);

    // Flush with start in idle: no accept. Flush alone in idle: no effect.
    start = 1'b1; cancel = 1'b1; op = 3'd0; opa = 32'd5; opb = 32'd5;
    tick(); start = 1'b0; run(3);
    check("cancel_start_nwr", n_writes, w);
    cancel = 1'b1; tick(); cancel = 1'b0;
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF); run(3);
    last_is("multu_max", 32'hFFFFFFFE, 32'h00000001, w + 1);

    // Start while a divide is in flight is ignored.
    w = n_writes;
    issue(3'd3, 32'd50, 32'd5); run(2);
    start = 1'b1; op = 3'd0; opa = 32'd3; opb = 32'd3; tick(); start = 1'b0;
    run(36);
    last_is("start_in_div", 32'd0, 32'd10, w + 1);

    // Reset mid-divide aborts with no write.
    w = n_writes;
    issue(3'd2, 32'd1000, 32'd3); run(5);
    rst = 1'b1; abort(cyc); tick(); rst = 1'b0;
    run(40);
    check("rst_div_nwr", n_writes, w);

`ifdef HILO_MADD_EN
    pin_model("madd", 3'd4, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 0);
    issue(3'd4, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF); run(3);
    last_is("madd", 32'd1, 32'd0, w + 1);
    issue(3'd6, 32'd1, 32'd1, 32'd0, 32'd0); run(3);
    last_is("msub", 32'hFFFFFFFF, 32'hFFFFFFFF, w + 2);
`else
    issue(3'd4, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF); run(4);
    check("madd_nop_nwr", n_writes, w);
    issue(3'd0, 32'd4, 32'd5); run(3);
    last_is("mult_after_nop", 32'd0, 32'd20, w + 1);
`endif

    run(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
